// File: rtl/audio_voice_scheduler.sv
// Shares one 32-bit music RAM port between a music voice and NUM_SFX effect voices:
// one read slot per voice per sample tick, then a saturating mix into an unsigned 8-bit sample.
module audio_voice_scheduler #(
  parameter int ADDR_W   = 15,
  parameter int NUM_SFX  = 2,
  parameter int RD_LAT   = 1,
  parameter int TICK_DIV = 6250
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          music_start,
  input  logic                          music_stop,
  input  logic                          music_loop,
  input  logic [ADDR_W+1:0]             music_base,
  input  logic [ADDR_W+1:0]             music_len,
  input  logic [NUM_SFX-1:0]            sfx_trig,
  input  logic [NUM_SFX*(ADDR_W+2)-1:0] sfx_base,
  input  logic [NUM_SFX*(ADDR_W+2)-1:0] sfx_len,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_en,
  input  logic [31:0]                   mem_dout,
  output logic [7:0]                    sample,
  output logic                          sample_valid,
  output logic                          music_busy,
  output logic [NUM_SFX-1:0]            sfx_busy
);
  localparam int AW = ADDR_W + 2;
  localparam int NV = NUM_SFX + 1;
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, SLOT = 2'd1, MIX = 2'd2} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         slot;
  logic [1:0]         sc;
  logic signed [10:0] acc;
  logic [AW-1:0]      ptr [NV];
  logic [AW-1:0]      rem [NV];
  logic [NV-1:0]      act;
  logic [NV-1:0]      pend;
  logic [AW-1:0]      lbase [NV];
  logic [AW-1:0]      llen [NV];
  logic               pend_stop;
  logic [AW-1:0]      loop_base;
  logic [AW-1:0]      loop_len;

  logic               tick;
  logic               cap;
  logic               stop_c;
  logic               music_go;
  logic [NV-1:0]      req;
  logic [NV-1:0]      commit;
  logic [AW-1:0]      rbase [NV];
  logic [AW-1:0]      rlen [NV];
  logic [AW-1:0]      cbase [NV];
  logic [AW-1:0]      clen [NV];
  logic [AW-1:0]      ptr_n [NV];
  logic [AW-1:0]      rem_n [NV];
  logic [NV-1:0]      act_n;
  logic [1:0]         cur_off;
  logic               cur_act;
  logic [7:0]         smp_byte;
  logic signed [10:0] acc_n;
  logic [2:0]         nxt_slot;
  logic               nxt_act;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [7:0]         mix;

  // Commit/advance next-state for every voice, the captured byte, and the clamped mix.
  always_comb begin
    tick   = (cnt == CW'(TICK_DIV - 1));
    cap    = (state == SLOT) && (sc == 2'(RD_LAT));
    stop_c = tick && (pend_stop || music_stop);
    req[0]   = music_start;
    rbase[0] = music_base;
    rlen[0]  = music_len;
    for (int v = 1; v < NV; v++) begin
      req[v]   = sfx_trig[v-1];
      rbase[v] = sfx_base[(v-1)*AW +: AW];
      rlen[v]  = sfx_len[(v-1)*AW +: AW];
    end
    cur_off = 2'd0;
    cur_act = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (slot == 3'(v)) begin
        cur_off = ptr[v][1:0];
        cur_act = act[v];
      end else begin
        cur_off = cur_off;
      end
    end
    smp_byte = 8'(mem_dout >> {cur_off, 3'b000});
    if (cap && cur_act) acc_n = acc + ($signed({3'b000, smp_byte}) - 11'sd128);
    else                acc_n = acc;
    for (int v = 0; v < NV; v++) begin
      cbase[v]  = req[v] ? rbase[v] : lbase[v];
      clen[v]   = req[v] ? rlen[v] : llen[v];
      commit[v] = tick && (pend[v] || req[v]);
      ptr_n[v]  = ptr[v];
      rem_n[v]  = rem[v];
      act_n[v]  = act[v];
      if (v == 0 && stop_c) begin
        act_n[v] = 1'b0;
      end else if (commit[v]) begin
        ptr_n[v] = cbase[v];
        rem_n[v] = clen[v];
        act_n[v] = (clen[v] != '0);
      end else if (cap && act[v] && slot == 3'(v)) begin
        ptr_n[v] = ptr[v] + AW'(1);
        rem_n[v] = rem[v] - AW'(1);
        // The last byte has been captured; music may wrap instead of ending.
        if (rem[v] == AW'(1)) begin
          if (v == 0 && music_loop) begin
            ptr_n[v] = loop_base;
            rem_n[v] = loop_len;
          end else begin
            act_n[v] = 1'b0;
          end
        end else begin
          act_n[v] = act[v];
        end
      end else begin
        act_n[v] = act[v];
      end
    end
    music_go = commit[0] && !stop_c;
    nxt_slot = (state == IDLE) ? 3'd0 : slot + 3'd1;
    nxt_act  = 1'b0;
    nxt_addr = '0;
    for (int v = 0; v < NV; v++) begin
      if (nxt_slot == 3'(v)) begin
        nxt_act  = act_n[v];
        nxt_addr = ptr_n[v][AW-1:2];
      end else begin
        nxt_act = nxt_act;
      end
    end
    if (acc_n > 11'sd127)       mix = 8'd255;
    else if (acc_n < -11'sd128) mix = 8'd0;
    else                        mix = 8'(acc_n + 11'sd128);
    music_busy = act[0];
    for (int i = 0; i < NUM_SFX; i++) sfx_busy[i] = act[i+1];
  end

  // Tick counter, request latching, voice state and the frame sequencer with its outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      state        <= IDLE;
      slot         <= 3'd0;
      sc           <= 2'd0;
      acc          <= '0;
      act          <= '0;
      pend         <= '0;
      pend_stop    <= 1'b0;
      loop_base    <= '0;
      loop_len     <= '0;
      sample       <= 8'd128;
      sample_valid <= 1'b0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      for (int v = 0; v < NV; v++) begin
        ptr[v]   <= '0;
        rem[v]   <= '0;
        lbase[v] <= '0;
        llen[v]  <= '0;
      end
    end else begin
      cnt       <= tick ? '0 : cnt + CW'(1);
      act       <= act_n;
      pend      <= tick ? '0 : (pend | req);
      pend_stop <= tick ? 1'b0 : (pend_stop | music_stop);
      acc       <= acc_n;
      mem_en       <= 1'b0;
      sample_valid <= 1'b0;
      for (int v = 0; v < NV; v++) begin
        ptr[v] <= ptr_n[v];
        rem[v] <= rem_n[v];
        if (req[v]) begin
          lbase[v] <= rbase[v];
          llen[v]  <= rlen[v];
        end
      end
      if (music_go) begin
        loop_base <= cbase[0];
        loop_len  <= clen[0];
      end
      case (state)
        IDLE: if (tick) begin
          state    <= SLOT;
          slot     <= 3'd0;
          sc       <= 2'd0;
          mem_en   <= nxt_act;
          mem_addr <= nxt_addr;
        end
        SLOT: if (sc == 2'(RD_LAT)) begin
          if (slot == 3'(NUM_SFX)) begin
            state        <= MIX;
            sample       <= mix;
            sample_valid <= 1'b1;
            acc          <= '0;
          end else begin
            slot     <= nxt_slot;
            sc       <= 2'd0;
            mem_en   <= nxt_act;
            mem_addr <= nxt_addr;
          end
        end else begin
          sc <= sc + 2'd1;
        end
        MIX:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Bench for audio_voice_scheduler: per-cycle comparison against a frame-level voice model,
// a table of mixing vectors, directed multi-frame sequences and random triggering.
module tb_audio_voice_scheduler;
  localparam int ADDR_W = 15, NUM_SFX = 2, RD_LAT = 1, TD = 16;
  localparam int AW = ADDR_W + 2, NV = NUM_SFX + 1;
  localparam int FL = NV * (RD_LAT + 1) + 1;

  logic clk = 1'b0, rst = 1'b1;
  logic music_start = 1'b0, music_stop = 1'b0, music_loop = 1'b0;
  logic [AW-1:0] music_base = '0, music_len = '0;
  logic [NUM_SFX-1:0] sfx_trig = '0;
  logic [NUM_SFX*AW-1:0] sfx_base = '0, sfx_len = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_en;
  logic [31:0] mem_dout = 32'd0;
  logic [7:0] sample;
  logic sample_valid, music_busy;
  logic [NUM_SFX-1:0] sfx_busy;

  audio_voice_scheduler #(.ADDR_W(ADDR_W), .NUM_SFX(NUM_SFX), .RD_LAT(RD_LAT), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .music_start(music_start), .music_stop(music_stop),
    .music_loop(music_loop), .music_base(music_base), .music_len(music_len),
    .sfx_trig(sfx_trig), .sfx_base(sfx_base), .sfx_len(sfx_len),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_dout(mem_dout),
    .sample(sample), .sample_valid(sample_valid),
    .music_busy(music_busy), .sfx_busy(sfx_busy));

  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr[9:0]];

  int errs = 0, checks = 0, c = 0;
  int m_act[NV], m_ptr[NV], m_rem[NV], m_pend[NV], m_pbase[NV], m_plen[NV];
  int m_pstop, m_lbase, m_llen;
  int f_on, f_T, f_sample, f_en[NV], f_addr[NV];
  int hold, last_valid;

  typedef struct { logic [7:0] m, s0, s1; logic [2:0] use_v; logic [7:0] exp; } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  function automatic int ram_byte(input int a);
    logic [31:0] w;
    w = ram[(a >> 2) % 1024];
    return int'((w >> (8 * (a % 4))) & 32'hFF);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0; m_ptr[v] = 0; m_rem[v] = 0; m_pend[v] = 0;
    end
    m_pstop = 0; f_on = 0; hold = 128;
  endtask

  // Frame-level view: commit pending requests, then each active voice plays one byte in order.
  task automatic model_frame();
    int acc;
    if (m_pstop != 0) m_act[0] = 0;
    else if (m_pend[0] != 0) begin
      m_ptr[0] = m_pbase[0]; m_rem[0] = m_plen[0]; m_act[0] = (m_plen[0] != 0);
      m_lbase = m_pbase[0]; m_llen = m_plen[0];
    end
    for (int v = 1; v < NV; v++)
      if (m_pend[v] != 0) begin
        m_ptr[v] = m_pbase[v]; m_rem[v] = m_plen[v]; m_act[v] = (m_plen[v] != 0);
      end
    for (int v = 0; v < NV; v++) m_pend[v] = 0;
    m_pstop = 0;
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      f_en[v] = m_act[v];
      f_addr[v] = m_ptr[v] / 4;
      if (m_act[v] != 0) begin
        acc += ram_byte(m_ptr[v]) - 128;
        m_ptr[v] = (m_ptr[v] + 1) % (1 << AW);
        m_rem[v]--;
        if (m_rem[v] == 0) begin
          if (v == 0 && music_loop) begin m_ptr[0] = m_lbase; m_rem[0] = m_llen; end
          else m_act[v] = 0;
        end
      end
    end
    f_sample = (acc > 127) ? 255 : (acc < -128) ? 0 : acc + 128;
    f_T = c; f_on = 1;
  endtask

  task automatic check_cycle();
    int d, k;
    bit inf, exp_en;
    logic [NV-1:0] eb;
    d = c - f_T;
    inf = (f_on != 0) && d >= 1 && d <= FL;
    k = (d - 1) / (RD_LAT + 1);
    exp_en = inf && d < FL && ((d - 1) % (RD_LAT + 1) == 0) && (f_en[k] != 0);
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en && mem_en) chk("mem_addr", 32'(mem_addr), 32'(f_addr[k]));
    chk("sample_valid", 32'(sample_valid), 32'(inf && d == FL));
    if (inf && d == FL) begin hold = f_sample; last_valid = 32'(sample); end
    chk("sample", 32'(sample), 32'(hold));
    if (!inf || d == FL) begin
      for (int v = 0; v < NV; v++) eb[v] = (m_act[v] != 0);
      chk("busy", 32'({sfx_busy, music_busy}), 32'(eb));
    end
  endtask

  // Consume this cycle's inputs in the model, advance one clock, then compare outputs.
  task automatic step();
    if (music_start) begin m_pend[0] = 1; m_pbase[0] = music_base; m_plen[0] = music_len; end
    for (int i = 0; i < NUM_SFX; i++)
      if (sfx_trig[i]) begin
        m_pend[i+1] = 1; m_pbase[i+1] = sfx_base[i*AW +: AW]; m_plen[i+1] = sfx_len[i*AW +: AW];
      end
    if (music_stop) m_pstop = 1;
    if (c % TD == TD - 1) model_frame();
    @(negedge clk);
    c++;
    music_start = 1'b0; music_stop = 1'b0; sfx_trig = '0;
    check_cycle();
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < TD && (c % TD) != TD - 1; i++) step();
  endtask

  task automatic frame();
    run_to_tick();
    repeat (FL + 1) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0; c = 0;
    model_reset();
    chk("rst_sample", 32'(sample), 32'd128);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'({sfx_busy, music_busy}), 32'd0);
  endtask

  task automatic set_sfx(input int i, input int b, input int l);
    sfx_base[i*AW +: AW] = AW'(b);
    sfx_len[i*AW +: AW]  = AW'(l);
  endtask

  initial begin
    int exp4[5], expl[7], expw[4];
    tbl[0]  = '{8'hFF, 8'hF0, 8'h00, 3'b011, 8'd255};
    tbl[1]  = '{8'h00, 8'h10, 8'h00, 3'b011, 8'd0};
    tbl[2]  = '{8'h81, 8'h00, 8'h00, 3'b001, 8'd129};
    tbl[3]  = '{8'h55, 8'h66, 8'h77, 3'b000, 8'd128};
    tbl[4]  = '{8'h90, 8'h90, 8'h90, 3'b111, 8'd176};
    tbl[5]  = '{8'h40, 8'hC0, 8'h00, 3'b011, 8'd128};
    tbl[6]  = '{8'hFF, 8'hFF, 8'hFF, 3'b111, 8'd255};
    tbl[7]  = '{8'h00, 8'h00, 8'h00, 3'b111, 8'd0};
    tbl[8]  = '{8'hA0, 8'hE0, 8'h00, 3'b011, 8'd255};
    tbl[9]  = '{8'h60, 8'h20, 8'h00, 3'b011, 8'd0};
    tbl[10] = '{8'h9F, 8'hE0, 8'h00, 3'b011, 8'd255};
    tbl[11] = '{8'h7F, 8'h80, 8'h00, 3'b011, 8'd127};
    tbl[12] = '{8'h00, 8'h00, 8'h00, 3'b001, 8'd0};
    tbl[13] = '{8'h20, 8'h00, 8'hC0, 3'b101, 8'd96};
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;

    do_reset(3);
    frame(); frame();

    // Music byte order within one word, then silence.
    ram[0] = 32'h8483_8281;
    exp4 = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h80};
    music_base = 17'd0; music_len = 17'd4; music_loop = 1'b0; music_start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      frame();
      chk("music_seq", 32'(last_valid), 32'(exp4[i]));
      if (i == 2) chk("music_busy_mid", 32'(music_busy), 32'd1);
      if (i == 3) chk("music_busy_end", 32'(music_busy), 32'd0);
    end

    // Mixing table, one single-byte burst per entry.
    for (int i = 0; i < 14; i++) begin
      ram[100] = {4{tbl[i].m}}; ram[200] = {4{tbl[i].s0}}; ram[300] = {4{tbl[i].s1}};
      music_base = 17'd400; music_len = 17'd1; music_start = tbl[i].use_v[0];
      set_sfx(0, 800, 1); set_sfx(1, 1200, 1);
      sfx_trig = tbl[i].use_v[2:1];
      step();
      frame();
      chk($sformatf("mix[%0d]", i), 32'(last_valid), 32'(tbl[i].exp));
    end

    // Looping music, then loop released mid-playback.
    ram[1] = 32'hA3A2_A1A0;
    expl = '{8'hA1, 8'hA2, 8'hA3, 8'hA1, 8'hA2, 8'hA3, 8'hA1};
    music_base = 17'd5; music_len = 17'd3; music_loop = 1'b1; music_start = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      frame();
      chk("loop_seq", 32'(last_valid), 32'(expl[i]));
      chk("loop_busy", 32'(music_busy), 32'd1);
    end
    music_loop = 1'b0;
    frame(); chk("unloop_a2", 32'(last_valid), 32'hA2);
    frame(); chk("unloop_a3", 32'(last_valid), 32'hA3);
    frame(); chk("unloop_end", 32'(last_valid), 32'd128);
    chk("unloop_busy", 32'(music_busy), 32'd0);

    // Byte pointer wraps at the top of the address space.
    ram[1023] = 32'hC4C3_C2C1;
    expw = '{8'hC3, 8'hC4, 8'h81, 8'h82};
    music_base = 17'h1FFFE; music_len = 17'd4; music_start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("wrap_seq", 32'(last_valid), 32'(expw[i]));
    end

    // Trigger three cycles after a tick, then retrigger to a new base.
    ram[25] = 32'h0000_00D0;
    run_to_tick();
    repeat (3) step();
    set_sfx(0, 48, 8); sfx_trig = 2'b01;
    step();
    frame(); frame();
    set_sfx(0, 100, 8); sfx_trig = 2'b01;
    step();
    frame();
    chk("retrig_byte", 32'(last_valid), 32'hD0);

    // Simultaneous start and stop.
    music_base = 17'd0; music_len = 17'd4; music_start = 1'b1; music_stop = 1'b1;
    step();
    frame();
    chk("collision_busy", 32'(music_busy), 32'd0);

    // Reset in the middle of an active frame.
    music_base = 17'd0; music_len = 17'd4; music_loop = 1'b1; music_start = 1'b1;
    step();
    frame();
    run_to_tick();
    repeat (3) step();
    do_reset(1);
    music_loop = 1'b0;
    repeat (2 * TD) step();

    // Random triggering against the model.
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        music_base = 17'($urandom_range(0, 4095)); music_len = 17'($urandom_range(0, 12));
        music_start = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) music_stop = 1'b1;
      for (int i = 0; i < NUM_SFX; i++)
        if ($urandom_range(0, 7) == 0) begin
          set_sfx(i, $urandom_range(0, 4095), $urandom_range(0, 12));
          sfx_trig[i] = 1'b1;
        end
      if (c % TD == 10) music_loop = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/audio_voice_scheduler.md
# audio_voice_scheduler

Shares the single 32-bit-wide music block RAM between one background-music voice and `NUM_SFX` sound-effect voices (drum "don"/"ka" hits). On each sample period the scheduler sequences one RAM read per voice, extracts the 8-bit sample byte for each voice, and mixes the voices with saturation. It presents the mixed 8-bit unsigned sample to the PWM generator. It replaces direct decoder ownership of the RAM port and sits between the memory and the PWM stage.

## Interface
Parameters:
- `ADDR_W`, 15: RAM word-address width. Byte addresses are `ADDR_W+2` bits wide.
- `NUM_SFX`, 2: number of sound-effect voices, 1..4.
- `RD_LAT`, 1: RAM read latency in cycles from `mem_en` to valid `mem_dout`, 1..2.
- `TICK_DIV`, 6250: clocks per sample period (16 kHz at 100 MHz). Must be greater than `(NUM_SFX+1)*(RD_LAT+1)+1`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `music_start`  in  1  pulse; starts or restarts music at `music_base`.
- `music_stop`  in  1  pulse; stops music.
- `music_loop`  in  1  level; when high, music wraps to its base at end.
- `music_base`  in  ADDR_W+2  music start byte address; latched on `music_start`.
- `music_len`  in  ADDR_W+2  music length in bytes; latched on `music_start`.
- `sfx_trig`  in  NUM_SFX  per-voice pulse; starts or retriggers voice i.
- `sfx_base`  in  NUM_SFX*(ADDR_W+2)  flattened start addresses; voice i is slice i. Latched on trigger.
- `sfx_len`  in  NUM_SFX*(ADDR_W+2)  flattened lengths in bytes. Latched on trigger.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_en`  out  1  RAM read enable, high one cycle per read.
- `mem_dout`  in  32  RAM read data. Byte 0 is in [7:0] and is the earliest sample.
- `sample`  out  8  mixed unsigned sample; 128 is silence.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `music_busy`  out  1  music voice is active.
- `sfx_busy`  out  NUM_SFX  per-voice active flags.

## Operation
- **Tick counter.** The counter runs 0..TICK_DIV-1 and wraps. `tick` is asserted when the counter equals TICK_DIV-1.
- **Pending requests.** `music_start`, `music_stop`, and `sfx_trig[i]` set pending flags and latch base/len. The flags commit only on a tick cycle. A pulse arriving in the tick cycle itself commits on that tick.
- **Retrigger.** A second trigger before commit overwrites the latched base/len.
- **Commit action.** A voice's pointer becomes base, its remaining count becomes len, and it goes active. If len = 0 the voice goes inactive instead.
- **Start/stop collision.** If `music_start` and `music_stop` are both pending at commit, stop wins. Pending flags clear on commit.
- **Frame FSM.** States are IDLE → SLOT(k), k = 0..NUM_SFX → MIX → IDLE.
  - Slot 0 is music; slot k is sfx voice k-1.
  - Each slot lasts exactly RD_LAT+1 cycles, whether or not the voice is active.
  - First cycle of an active slot: `mem_en`=1 and `mem_addr`=ptr[ADDR_W+1:2].
  - In the slot's last cycle, the byte selected by ptr[1:0] is captured from `mem_dout`.
  - Inactive slots keep `mem_en`=0 and contribute 0 to the mix.
- **Pointer advance.** After an active voice's read, ptr increments and remaining decrements.
  - When remaining reaches 0, the voice goes inactive after this frame's contribution, so the last byte is played.
  - If the voice is music and `music_loop`=1, it reloads ptr=base and remaining=len instead.
  - The ptr increment wraps modulo 2^(ADDR_W+2).
- **Mixing.** acc = Σ (byte − 128) over active voices, using signed ADDR-independent 11-bit arithmetic.
  - In MIX, acc is clamped to [−128, 127], then 128 is added, and the result is registered to `sample`.
  - `sample_valid` pulses in the MIX cycle, and acc clears.
- **Busy flags.** `music_busy` and `sfx_busy` reflect the active flags.
- **Reset.** Reset mid-frame aborts the frame with no `sample_valid`. Reset values:
  - counter 0, FSM IDLE, all voices inactive, all pending flags cleared
  - `sample`=8'd128, `sample_valid`=0, `mem_en`=0, `mem_addr`=0
  - `music_busy`=0, `sfx_busy`=0

## Timing
- Tick in cycle T. Commits are registered at T.
- Slot k's `mem_en` is in cycle T+1+k*(RD_LAT+1).
- Slot k's capture is in cycle T+1+k*(RD_LAT+1)+RD_LAT.
- `sample_valid` is in cycle T+1+(NUM_SFX+1)*(RD_LAT+1). With defaults that is T+7.
- `sample` holds its value between pulses.
- At most one `mem_en` per RD_LAT+1 cycles, never back-to-back with RD_LAT=1.
- Triggers arriving between ticks affect only the next frame; pointers never change mid-frame except by the voice's own advance.
- Exactly one `sample_valid` per tick after reset, including all-silent frames, which output 128.

## Test plan
- **Reset/idle.** Assert `rst` for 3 cycles, then run 2 ticks with no triggers.
  - Expect `sample`=128, a `sample_valid` at T+7 each tick, `mem_en` never high, and all busy flags 0.
- **Music byte sequencing.** RAM word 0 = 32'h8483_8281. Start music with base=0, len=4, loop=0.
  - Expect successive samples 0x81, 0x82, 0x83, 0x84, then 128 from the fifth tick on.
  - Expect `music_busy` to fall after the fourth frame and `mem_addr`=0 for all four reads.
- **Saturation.** Music bytes 0xFF and sfx0 bytes 0xF0 active together. Expect `sample`=255.
  - Then music 0x00 and sfx0 0x10. Expect `sample`=0.
- **Loop wrap.** Music base=5, len=3, loop=1.
  - Expect byte addresses 5, 6, 7, 5, 6, 7, …, with `mem_addr` 1, 1, 1, 1… and `music_busy` staying 1.
  - Set loop=0 during playback: expect the voice to stop after the next byte 7.
- **Trigger timing and retrigger.**
  - Pulse `sfx_trig[0]` 3 cycles after a tick: expect no slot-1 read in that frame, and a read at T'+3 on the next tick.
  - Retrigger mid-playback with base=100: expect the next frame to read byte 100 (`mem_addr`=25).
- **Collision and reset.**
  - Pulse `music_start` and `music_stop` in the same cycle: expect `music_busy` to remain 0.
  - Assert `rst` at T+3 of an active frame: expect no `sample_valid`, `sample`=128, and all voices inactive.
